// File: rtl/univ_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits with shift, rotate,
// parallel load, clear and a counted burst mode under start/busy/done.
module univ_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int NW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   en,
  input  logic [2:0]             mode,
  input  logic [WIDTH-1:0]       sin_r,
  input  logic [WIDTH-1:0]       sin_l,
  input  logic [WIDTH*DEPTH-1:0] pin,
  input  logic                   start,
  input  logic [NW-1:0]          nshift,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic [WIDTH-1:0]       sout_r,
  output logic [WIDTH-1:0]       sout_l,
  output logic                   busy,
  output logic                   done
);

  localparam int TW = WIDTH * DEPTH;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   data, data_n;
  logic [NW-1:0]   count, count_n;
  logic [2:0]      lmode, lmode_n;
  logic            done_n;
  logic            burst_ok;

  // Stage k lives at [k*WIDTH +: WIDTH]; "right" moves toward stage DEPTH-1.
  function automatic logic [TW-1:0] apply_op(
    input logic [2:0]       op,
    input logic [TW-1:0]    d,
    input logic [WIDTH-1:0] sr,
    input logic [WIDTH-1:0] sl,
    input logic [TW-1:0]    ld
  );
    logic [TW-1:0] r;
    r = d;
    case (op)
      3'b001:  r = {d[TW-WIDTH-1:0], sr};
      3'b010:  r = {sl, d[TW-1:WIDTH]};
      3'b011:  r = {d[TW-WIDTH-1:0], d[TW-1 -: WIDTH]};
      3'b100:  r = {d[WIDTH-1:0], d[TW-1:WIDTH]};
      3'b101:  r = ld;
      3'b110:  r = '0;
      default: r = d;
    endcase
    return r;
  endfunction

  assign burst_ok = start && (mode >= 3'b001) && (mode <= 3'b100);

  always_comb begin
    state_n = state;
    data_n  = data;
    count_n = count;
    lmode_n = lmode;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (burst_ok) begin
          lmode_n = mode;
          count_n = nshift;
          if (nshift == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = RUN;
          end
        end else if (en) begin
          data_n = apply_op(mode, data, sin_r, sin_l, pin);
        end
      end
      RUN: begin
        data_n  = apply_op(lmode, data, sin_r, sin_l, pin);
        count_n = count - NW'(1);
        if (count == NW'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      data  <= '0;
      count <= '0;
      lmode <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      data  <= data_n;
      count <= count_n;
      lmode <= lmode_n;
      done  <= done_n;
    end
  end

  assign pout   = data;
  assign sout_r = data[TW-1 -: WIDTH];
  assign sout_l = data[WIDTH-1:0];
  assign busy   = (state == RUN);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=4, DEPTH=4): queue-based reference model
// checked every cycle, plus literal expectations along the directed sequence.
module tb_univ_shift_reg;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int NW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          clr;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  sin_r, sin_l;
  logic [W*D-1:0] pin;
  logic          start;
  logic [NW-1:0] nshift;
  logic [W*D-1:0] pout;
  logic [W-1:0]  sout_r, sout_l;
  logic          busy, done;

  int checks = 0;
  int failures = 0;

  univ_shift_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode),
    .sin_r(sin_r), .sin_l(sin_l), .pin(pin),
    .start(start), .nshift(nshift),
    .pout(pout), .sout_r(sout_r), .sout_l(sout_l),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: q[k] is stage k.
  logic [W-1:0] q[$];
  int           rem;
  logic [2:0]   bop;
  bit           mbusy, mdone;

  function automatic logic [W*D-1:0] packq();
    logic [W*D-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++) r[k*W +: W] = q[k];
    return r;
  endfunction

  task automatic mclear();
    q = {};
    for (int k = 0; k < D; k++) q.push_back('0);
  endtask

  task automatic mop(input logic [2:0] op);
    case (op)
      3'd1: begin q.push_front(sin_r); void'(q.pop_back()); end
      3'd2: begin q.push_back(sin_l); void'(q.pop_front()); end
      3'd3: q.push_front(q.pop_back());
      3'd4: q.push_back(q.pop_front());
      3'd5: for (int k = 0; k < D; k++) q[k] = pin[k*W +: W];
      3'd6: mclear();
      default: ;
    endcase
  endtask

  initial mclear();

  always @(negedge clr) begin
    mclear();
    rem = 0; bop = 0; mbusy = 0; mdone = 0;
  end

  always @(posedge clk) begin
    if (clr) begin
      if (mbusy) begin
        mop(bop);
        rem--;
        mdone = (rem == 0);
        if (rem == 0) mbusy = 0;
      end else begin
        mdone = 0;
        if (start && mode inside {[3'd1:3'd4]}) begin
          bop = mode;
          rem = int'(nshift);
          if (rem == 0) mdone = 1;
          else mbusy = 1;
        end else if (en) begin
          mop(mode);
        end
      end
    end else begin
      mclear();
      rem = 0; mbusy = 0; mdone = 0;
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      chk("model_pout", pout, packq());
      chk("model_sout_r", sout_r, q[D-1]);
      chk("model_sout_l", sout_l, q[0]);
      chk("model_busy", busy, mbusy);
      chk("model_done", done, mdone);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic run_burst(input logic [2:0] m, input logic [NW-1:0] n);
    int t;
    mode = m; nshift = n; start = 1; en = 0;
    cyc();
    start = 0;
    t = 0;
    while (!done && t < 20) begin
      cyc();
      t++;
    end
    chk("burst_timeout", (t < 20), 1'b1);
  endtask

  int bc, dc;

  initial begin
    clr = 0; en = 0; mode = 0; sin_r = 0; sin_l = 0;
    pin = 0; start = 0; nshift = 0;
    repeat (2) cyc();
    chk("reset_pout", pout, 16'h0);
    chk("reset_busy", busy, 1'b0);
    clr = 1;
    cyc();

    // serial right shift, first input ends up in stage 3
    en = 1; mode = 3'd1;
    foreach (pin[i]) ;
    sin_r = 4'h1; cyc();
    sin_r = 4'h1; cyc();
    sin_r = 4'h0; cyc();
    sin_r = 4'h1; cyc();
    chk("sr_pout", pout, 16'h1101);
    chk("sr_sout_r", sout_r, 4'h1);
    sin_r = 4'h0; cyc();
    chk("sr2_pout", pout, 16'h1010);
    chk("sr2_sout_r", sout_r, 4'h1);

    // load and single rotates
    mode = 3'd5; pin = 16'h4321; cyc();
    chk("load", pout, 16'h4321);
    mode = 3'd3; cyc();
    chk("rotr1", pout, 16'h3214);
    mode = 3'd4; cyc();
    chk("rotl1", pout, 16'h4321);
    mode = 3'd7; cyc();
    chk("reserved_hold", pout, 16'h4321);

    // burst rotate right 3 with en/mode noise
    start = 1; mode = 3'd3; nshift = 3; en = 1; pin = 16'hffff;
    cyc();
    start = 0;
    chk("burst_start_hold", pout, 16'h4321);
    bc = 0; dc = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) bc++;
      if (done) dc++;
      mode = (i % 2 == 0) ? 3'd5 : 3'd1;
      en = busy;
      cyc();
    end
    chk("burst_busy_cycles", bc, 3);
    chk("burst_done_cycles", dc, 1);
    chk("burst_pout", pout, 16'h1432);

    // nshift = 0
    en = 0; start = 1; mode = 3'd3; nshift = 0; cyc();
    start = 0;
    chk("n0_done", done, 1'b1);
    chk("n0_busy", busy, 1'b0);
    chk("n0_pout", pout, 16'h1432);
    cyc();
    chk("n0_done_clear", done, 1'b0);

    // start held through busy, relaunch in the done cycle
    start = 1; mode = 3'd4; nshift = 2; cyc();
    mode = 3'd3; nshift = 1; cyc();
    chk("b2b_mid", pout, 16'h2143);
    cyc();
    chk("b2b_done1", done, 1'b1);
    chk("b2b_pout1", pout, 16'h3214);
    cyc();
    start = 0;
    chk("b2b_busy2", busy, 1'b1);
    chk("b2b_nodone", done, 1'b0);
    cyc();
    chk("b2b_done2", done, 1'b1);
    chk("b2b_pout2", pout, 16'h2143);
    cyc();

    // rotate by DEPTH is identity; shift left past DEPTH fills with sin_l
    en = 1; mode = 3'd5; pin = 16'h4321; cyc();
    run_burst(3'd4, 3'd4);
    chk("rot_depth", pout, 16'h4321);
    sin_l = 4'hf;
    run_burst(3'd2, 3'd5);
    chk("shl5", pout, 16'hffff);
    en = 1; mode = 3'd6; cyc();
    chk("clear", pout, 16'h0);
    en = 0;

    // reset mid-burst
    sin_r = 4'ha; start = 1; mode = 3'd1; nshift = 5; cyc();
    start = 0;
    cyc(); cyc();
    chk("pre_reset_nz", (pout != 0), 1'b1);
    @(posedge clk);
    #2 clr = 0;
    #1;
    chk("async_pout", pout, 16'h0);
    chk("async_busy", busy, 1'b0);
    chk("async_done", done, 1'b0);
    cyc();
    clr = 1;
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (done || busy) dc++;
    end
    chk("post_reset_quiet", dc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
